// File: rtl/shifter_pkg.sv
// Shared constants, instruction-type encodings and FSM state type for the
// sequential left shifter.
package shifter_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic TYPE_R = 1'b0;  // SLL: amount from in2[4:0]
  localparam logic TYPE_I = 1'b1;  // SLLI: amount from shamt

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_left_shifter.sv
// Iterative logical left shifter: one bit per cycle, valid/ready on both sides.
// A zero-amount request skips SHIFT and still costs one cycle before out_valid.
module seq_left_shifter
  import shifter_pkg::*;
#(
  parameter int XLEN = shifter_pkg::XLEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in1,
  input  logic                op_type,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [XLEN-1:0]     in2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     shifted
);

  state_t               state;
  logic [XLEN-1:0]      result;
  logic [SHAMT_W-1:0]   cnt;
  logic [SHAMT_W-1:0]   amt;
  logic                 unused_in2;

  // Only the low SHAMT_W bits of the register operand select the amount.
  assign unused_in2 = ^in2[XLEN-1:SHAMT_W];

  always_comb begin
    amt = in2[SHAMT_W-1:0];
    if (op_type == TYPE_I) amt = shamt;
  end

  // NOTE: state is updated only with non-blocking assignments so every branch
  // reads the pre-edge values; reset is sampled synchronously, so it is the
  // first test inside the clocked block rather than part of the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      result    <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            result   <= in1;
            cnt      <= amt;
            in_ready <= 1'b0;
            state    <= (amt == '0) ? ST_DONE : ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          result <= {result[XLEN-2:0], 1'b0};
          cnt    <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end

        ST_DONE: begin
          // Entered straight from IDLE with a zero amount: raise out_valid one
          // cycle later so every request costs at least one cycle.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign shifted = result;

endmodule

// File: tb/tb_seq_left_shifter.sv
// Self-checking bench for seq_left_shifter: directed corner cases followed by
// randomized back-to-back requests against a shift-operator reference model.
module tb_seq_left_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic        typ;
  logic [4:0]  shamt;
  logic [31:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] shifted;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_left_shifter #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .op_type   (typ),
    .shamt     (shamt),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .shifted   (shifted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure latency, check result, then drain it after
  // holding out_ready low for 'hold' cycles in DONE.
  task automatic run_req(input string tag, input logic t, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] s, input int hold);
    int          amt;
    int          exp_lat;
    int          lat;
    int          k;
    logic [31:0] exp;
    amt     = (t == 1'b1) ? int'(s) : int'(b % 32);
    exp     = a << amt;
    exp_lat = (amt == 0) ? 1 : amt;

    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    check({tag, " ready"}, 32'(in_ready), 32'd1);

    in_valid = 1'b1; typ = t; in1 = a; in2 = b; shamt = s; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom; shamt = 5'($urandom); typ = 1'($urandom);
    check({tag, " accept_busy"}, {30'd0, in_ready, out_valid}, 32'd0);

    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (out_valid) break;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, shifted, exp);

    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold"}, {in_ready, out_valid, shifted[29:0]}, {1'b0, 1'b1, exp[29:0]});
    end

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " release"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    logic [31:0] hold_val;
    rst_n = 1'b0; in_valid = 1'b0; in1 = '0; typ = 1'b0; shamt = '0; in2 = '0; out_ready = 1'b0;
    tick();
    tick();
    check("reset_state", {in_ready, out_valid, shifted[29:0]}, {1'b1, 1'b0, 30'd0});
    check("reset_shifted", shifted, 32'd0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", 32'(in_ready), 32'd1);

    run_req("sll_i_31", 1'b1, 32'h0000_0001, 32'h0, 5'd31, 0);
    run_req("sll_r_upper_ignored", 1'b0, 32'h8000_0001, 32'h0000_0021, 5'd7, 0);
    run_req("sll_i_zero", 1'b1, 32'hDEAD_BEEF, 32'h0000_0005, 5'd0, 0);
    run_req("sll_r_zero", 1'b0, 32'h1234_5678, 32'hFFFF_FFE0, 5'd9, 1);

    // Stall in DONE with a competing request on the input side.
    run_req("stall_pre", 1'b1, 32'h0, 32'h0, 5'd1, 0);
    in_valid = 1'b1; typ = 1'b1; in1 = 32'h0000_00FF; shamt = 5'd4;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6 && !out_valid; i++) tick();
    check("stall_result", shifted, 32'h0000_0FF0);
    in_valid = 1'b1; in1 = 32'hFFFF_FFFF; shamt = 5'd3; typ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", {in_ready, out_valid, shifted[29:0]}, {1'b0, 1'b1, 30'h0000_0FF0});
    end
    check("stall_shifted", shifted, 32'h0000_0FF0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_release", {30'd0, in_ready, out_valid}, 32'd2);
    tick();
    check("stall_no_ghost", {in_ready, out_valid, shifted[29:0]}, {1'b1, 1'b0, 30'h0000_0FF0});

    // Reset in the middle of a long shift.
    in_valid = 1'b1; typ = 1'b1; in1 = 32'h1; shamt = 5'd20;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_state", {in_ready, out_valid, shifted[29:0]}, {1'b1, 1'b0, 30'd0});
    check("midreset_shifted", shifted, 32'd0);
    hold_val = 32'd0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) hold_val = 32'd1;
    end
    check("midreset_no_result", hold_val, 32'd0);
    run_req("after_reset", 1'b1, 32'h0000_0003, 32'h0, 5'd20, 0);

    // Every shift amount, alternating the amount source.
    for (int a = 0; a < 32; a++) begin
      logic [31:0] r2;
      r2 = ($urandom & 32'hFFFF_FFE0) | 32'(a);
      run_req("sweep", 1'(a), $urandom, r2, 5'(a), 0);
    end

    // Randomized back-to-back traffic with random consumer stalls.
    for (int i = 0; i < 30; i++) begin
      run_req("random", 1'($urandom), $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_left_shifter.md
SEQ_LEFT_SHIFTER -- requirements
Module: seq_left_shifter

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; the only legal value is 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in1  input  32  operand to shift.
REQ-007 type  input  1  shift-amount source: 0 = R-type (SLL), 1 = I-type (SLLI).
REQ-008 shamt  input  5  immediate shift amount, used when type=1.
REQ-009 in2  input  32  register shift amount, used when type=0; only in2[4:0] is significant.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 shifted  output  32  logical-left-shifted result, zero-filled.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 A request SHALL be accepted on an edge where in_valid=1 and in_ready=1; in1, type, shamt and in2 are sampled only at that edge.
REQ-016 On accept, amt SHALL equal shamt when type=1 and in2[4:0] when type=0; upper in2 bits SHALL be ignored.
REQ-017 On accept with amt=0, the FSM SHALL go IDLE->DONE with the result register equal to in1.
REQ-018 On accept with amt>0, the FSM SHALL load the result register with in1, load a 5-bit counter with amt, and go to SHIFT.
REQ-019 Each SHIFT cycle SHALL shift the result register left by one (LSB filled with 0) and decrement the counter; on the cycle the counter is 1, the FSM SHALL go to DONE.
REQ-020 Latency: out_valid SHALL rise exactly max(amt,1) rising edges after the accepting edge.
REQ-021 In DONE, shifted SHALL hold stable while out_ready=0; on an edge with out_ready=1, the FSM SHALL return to IDLE.
REQ-022 in_valid during SHIFT or DONE SHALL be ignored, with no effect on state or data.
REQ-023 out_ready outside DONE SHALL be ignored.
REQ-024 shifted SHALL equal the result register in all states; its value outside DONE is don't-care for consumers.
REQ-025 The final result SHALL equal (in1 << amt) truncated to 32 bits for all 32 amt values.

Reset
REQ-026 On an edge with rst_n=0, the FSM SHALL be in IDLE, the result register 0x0000_0000, the counter 0, and out_valid 0, regardless of state.
REQ-027 Reset mid-SHIFT or mid-DONE SHALL discard the operation with no result delivered.
REQ-028 in_ready SHALL be 1 on the first edge after rst_n returns to 1.

Structure
REQ-029 A shared package shifter_pkg SHALL hold the XLEN constant, the SHAMT_W=5 constant, the type encodings (TYPE_R=0, TYPE_I=1) and the FSM state typedef.
REQ-030 The block SHALL be a single module with no sub-modules; the amount-select mux is inline.

Verification
REQ-031 Scenario: type=1, in1=0x0000_0001, shamt=31 -> out_valid after 31 edges, shifted=0x8000_0000.
REQ-032 Scenario: type=0, in1=0x8000_0001, in2=0x0000_0021 -> effective amt=1, out_valid after 1 edge, shifted=0x0000_0002.
REQ-033 Scenario: type=1, in1=0xDEAD_BEEF, shamt=0 -> out_valid after 1 edge, shifted=0xDEAD_BEEF.
REQ-034 Scenario: type=1, in1=0x0000_00FF, shamt=4, out_ready=0 for 5 cycles in DONE -> shifted=0x0000_0FF0 stays stable, in_ready=0 throughout, and a second in_valid during that time is ignored.
REQ-035 Scenario: rst_n=0 asserted for one edge during SHIFT (in1=0x1, shamt=20) -> next cycle IDLE, in_ready=1, out_valid=0, shifted=0; the following request completes normally.
REQ-036 Scenario: randomized type/in1/in2/shamt back-to-back -> every result matches a reference model (in1 << amt) and every latency matches REQ-020.
